// File: rtl/led_flow_pkg.sv
// Shared mode encoding and the automatic mode sequence for the LED flow sequencer.
package led_flow_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHL   = 2'b01,
    MODE_SHR   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  // HOLD is only the power-on mode; the auto loop cycles SHL -> SHR -> BLINK.
  function automatic mode_e next_auto_mode(mode_e cur);
    case (cur)
      MODE_HOLD:  return MODE_SHL;
      MODE_SHL:   return MODE_SHR;
      MODE_SHR:   return MODE_BLINK;
      default:    return MODE_SHL;
    endcase
  endfunction

endpackage

// File: rtl/led_flow_seq_if.sv
// Control inputs and LED/status outputs of the LED flow sequencer.
interface led_flow_seq_if #(
  parameter int LED_W          = 8,
  parameter int STEPS_PER_MODE = 16
);
  localparam int CNT_W = $clog2(STEPS_PER_MODE);

  logic             flag;
  logic             en;
  logic [1:0]       mode_sel;
  logic             auto_mode;
  logic [LED_W-1:0] led;
  logic             step_pulse;
  logic [1:0]       mode;
  logic [CNT_W-1:0] step_cnt;

  modport master (
    output flag, en, mode_sel, auto_mode,
    input  led, step_pulse, mode, step_cnt
  );

  modport slave (
    input  flag, en, mode_sel, auto_mode,
    output led, step_pulse, mode, step_cnt
  );

endinterface

// File: rtl/flag_edge_detect.sv
// Registered any-edge detector: one-cycle pulse for each change of din.
module flag_edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic din_d;

  // NOTE: non-blocking assignments let din_d and pulse both see the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_d <= RST_VAL;
      pulse <= 1'b0;
    end else begin
      din_d <= din;
      pulse <= din ^ din_d;
    end
  end

endmodule

// File: rtl/led_flow_seq.sv
// LED pattern sequencer stepped by every edge of the counter's toggling flag.
module led_flow_seq
  import led_flow_pkg::*;
#(
  parameter int LED_W          = 8,
  parameter int STEPS_PER_MODE = 16
) (
  input  logic          clk,
  input  logic          reset,
  led_flow_seq_if.slave bus
);

  localparam int               CNT_W    = $clog2(STEPS_PER_MODE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS_PER_MODE - 1);
  localparam logic [LED_W-1:0] LED_RST  = LED_W'(1);

  logic             step_pulse;
  logic             step_en;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0] led_q, led_d;

  flag_edge_detect #(.RST_VAL(1'b1)) u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (bus.flag),
    .pulse (step_pulse)
  );

  assign step_en = step_pulse & bus.en;

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    if (step_en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
    if (bus.auto_mode) begin
      if (step_en && (cnt_q == CNT_LAST)) begin
        mode_d = next_auto_mode(mode_q);
      end
    end else begin
      // A manual mode change restarts the count, overriding any increment above.
      mode_d = mode_e'(bus.mode_sel);
      if (mode_d != mode_q) begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_HOLD;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

  // The pattern always follows the registered mode, even when mode changes this cycle.
  always_comb begin
    led_d = led_q;
    if (step_en) begin
      case (mode_q)
        MODE_SHL:   led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        MODE_SHR:   led_d = {led_q[0], led_q[LED_W-1:1]};
        MODE_BLINK: led_d = ~led_q;
        default:    led_d = led_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= LED_RST;
    end else begin
      led_q <= led_d;
    end
  end

  assign bus.led        = led_q;
  assign bus.mode       = mode_q;
  assign bus.step_cnt   = cnt_q;
  assign bus.step_pulse = step_pulse;

endmodule

// File: tb/tb_led_flow_seq.sv
// Scoreboard bench for led_flow_seq: stimulus queues expected post-step state, a monitor checks on each pulse.
module tb_led_flow_seq;

    localparam int LED_W = 8;
    localparam int SPM   = 4;

    typedef struct packed {
        logic [7:0] led;
        logic [1:0] mode;
        logic [1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_flow_seq_if #(.LED_W(LED_W), .STEPS_PER_MODE(SPM)) bus ();

    led_flow_seq #(.LED_W(LED_W), .STEPS_PER_MODE(SPM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t q[$];
    exp_t m;
    int   total = 0;
    int   bad   = 0;
    int   exp_mode_at[4] = '{1, 2, 3, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] tb_next(input logic [1:0] md);
        case (md)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            2'd2:    return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    function automatic exp_t model_step(input exp_t s, input logic en_v, input logic auto_v);
        exp_t r;
        r = s;
        if (en_v) begin
            case (s.mode)
                2'd1:    r.led = {s.led[6:0], s.led[7]};
                2'd2:    r.led = {s.led[0], s.led[7:1]};
                2'd3:    r.led = ~s.led;
                default: r.led = s.led;
            endcase
            if (s.cnt == 2'(SPM - 1)) begin
                r.cnt = 2'd0;
                if (auto_v) r.mode = tb_next(s.mode);
            end else begin
                r.cnt = s.cnt + 2'd1;
            end
        end
        return r;
    endfunction

    task automatic step_flag();
        @(negedge clk);
        m = model_step(m, bus.en, bus.auto_mode);
        q.push_back(m);
        bus.flag = ~bus.flag;
        @(negedge clk);
        check("pulse_latency", 32'(bus.step_pulse), 32'd1);
        repeat (19) @(negedge clk);
    endtask

    task automatic do_reset(input logic auto_v);
        @(negedge clk);
        reset         = 1'b1;
        bus.flag      = 1'b1;
        bus.auto_mode = auto_v;
        bus.mode_sel  = 2'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m = '{8'h01, 2'd0, 2'd0};
        check("reset_led",  32'(bus.led),      32'h01);
        check("reset_mode", 32'(bus.mode),     32'd0);
        check("reset_cnt",  32'(bus.step_cnt), 32'd0);
    endtask

    task automatic set_sel(input logic [1:0] v);
        @(negedge clk);
        bus.mode_sel = v;
        @(negedge clk);
        if (v != m.mode) m.cnt = 2'd0;
        m.mode = v;
        check("sel_mode", 32'(bus.mode),     32'(m.mode));
        check("sel_cnt",  32'(bus.step_cnt), 32'(m.cnt));
    endtask

    // Monitor: each pulse pops one expectation and compares the state one cycle later.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.step_pulse === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got pulse expected none at %0t", $time);
                end else begin
                    e = q.pop_front();
                    @(negedge clk);
                    check("sb_led",      32'(bus.led),        32'(e.led));
                    check("sb_mode",     32'(bus.mode),       32'(e.mode));
                    check("sb_cnt",      32'(bus.step_cnt),   32'(e.cnt));
                    check("pulse_width", 32'(bus.step_pulse), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset         = 1'b1;
        bus.flag      = 1'b1;
        bus.en        = 1'b1;
        bus.mode_sel  = 2'd0;
        bus.auto_mode = 1'b0;
        m             = '{8'h01, 2'd0, 2'd0};

        // Reset state and no spurious pulse with flag=1
        do_reset(1'b0);
        repeat (10) begin
            @(negedge clk);
            check("no_spurious_pulse", 32'(bus.step_pulse), 32'd0);
        end

        // Manual SHL, three steps
        set_sel(2'd1);
        repeat (3) step_flag();
        check("t2_led", 32'(bus.led),      32'h08);
        check("t2_cnt", 32'(bus.step_cnt), 32'd3);

        // Rotate/invert wrap cases
        do_reset(1'b0);
        set_sel(2'd1);
        repeat (7) step_flag();
        check("shl7_led", 32'(bus.led), 32'h80);
        step_flag();
        check("shl8_led", 32'(bus.led), 32'h01);

        do_reset(1'b0);
        set_sel(2'd2);
        step_flag();
        check("shr1_led", 32'(bus.led), 32'h80);

        do_reset(1'b0);
        set_sel(2'd3);
        step_flag();
        check("blink1_led", 32'(bus.led), 32'hFE);
        step_flag();
        check("blink2_led", 32'(bus.led), 32'h01);

        // Auto mode cycling
        do_reset(1'b1);
        for (int i = 1; i <= 17; i++) begin
            step_flag();
            if (i == 3) check("auto_hold_led", 32'(bus.led), 32'h01);
            if ((i % 4) == 0) begin
                check("auto_mode_adv", 32'(bus.mode),     32'(exp_mode_at[i/4 - 1]));
                check("auto_cnt_wrap", 32'(bus.step_cnt), 32'd0);
            end
        end
        check("auto_end_led",  32'(bus.led),      32'h02);
        check("auto_end_mode", 32'(bus.mode),     32'd1);
        check("auto_end_cnt",  32'(bus.step_cnt), 32'd1);

        // en=0 freezes state but pulses continue; manual change still applies
        do_reset(1'b0);
        set_sel(2'd1);
        step_flag();
        @(negedge clk);
        bus.en = 1'b0;
        repeat (5) step_flag();
        check("en0_led",  32'(bus.led),      32'h02);
        check("en0_cnt",  32'(bus.step_cnt), 32'd1);
        check("en0_mode", 32'(bus.mode),     32'd1);
        set_sel(2'd2);
        check("en0_sel_led", 32'(bus.led), 32'h02);
        @(negedge clk);
        bus.en = 1'b1;

        // Reset in the same cycle as step_pulse
        do_reset(1'b0);
        set_sel(2'd1);
        repeat (4) step_flag();
        check("pre_rst_led", 32'(bus.led), 32'h10);
        @(negedge clk);
        q.push_back('{8'h01, 2'd0, 2'd0});
        bus.flag = ~bus.flag;
        @(negedge clk);
        check("rst_pulse_seen", 32'(bus.step_pulse), 32'd1);
        reset        = 1'b1;
        bus.flag     = 1'b1;
        bus.mode_sel = 2'd0;
        @(negedge clk);
        reset = 1'b0;
        m = '{8'h01, 2'd0, 2'd0};
        repeat (18) @(negedge clk);
        check("post_rst_led",  32'(bus.led),      32'h01);
        check("post_rst_mode", 32'(bus.mode),     32'd0);
        check("post_rst_cnt",  32'(bus.step_cnt), 32'd0);

        // Mode change in the same cycle as a step: old mode drives led, count clears
        set_sel(2'd1);
        repeat (4) step_flag();
        check("pre_chg_led", 32'(bus.led), 32'h10);
        @(negedge clk);
        q.push_back('{8'h20, 2'd2, 2'd0});
        bus.flag = ~bus.flag;
        @(negedge clk);
        check("chg_pulse_seen", 32'(bus.step_pulse), 32'd1);
        bus.mode_sel = 2'd2;
        @(negedge clk);
        m = '{8'h20, 2'd2, 2'd0};
        repeat (18) @(negedge clk);

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
